// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int LINE_W = 512;
    localparam int OFF_W  = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        FILL,
        RESP,
        FLUSH_SCAN,
        FLUSH_WB
    } state_t;

    // Overlay the strobed bytes of one core word onto a line at word slot word_idx.
    function automatic logic [LINE_W-1:0] merge_word(
        input logic [LINE_W-1:0] line,
        input logic [63:0]       word,
        input logic [7:0]        strb,
        input int                word_idx,
        input int                word_bytes
    );
        logic [LINE_W-1:0] res;
        res = line;
        for (int b = 0; b < 8; b++) begin
            if ((b < word_bytes) && strb[b])
                res[(word_idx * word_bytes + b) * 8 +: 8] = word[b * 8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// Line-memory port of the data cache: drequest held until dreqack, ddone pulse ends the transaction.
interface dcache_wb_if;
    import dcache_pkg::*;

    logic              drequest;
    logic              dreqack;
    logic              dwrenable;
    logic [63:0]       daddr;
    logic [LINE_W-1:0] drdata;
    logic [LINE_W-1:0] dwdata;
    logic              ddone;

    modport master (
        output drequest, dwrenable, daddr, dwdata,
        input  dreqack, drdata, ddone
    );

    modport slave (
        input  drequest, dwrenable, daddr, dwdata,
        output dreqack, drdata, ddone
    );

endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read, one synchronous write port, async clear of valid/dirty.
module dcache_array
    import dcache_pkg::*;
#(
    parameter  int SETS  = 64,
    parameter  int TAG_W = 52,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IDX_W-1:0]  ridx,
    output logic [LINE_W-1:0] rline,
    output logic [TAG_W-1:0]  rtag,
    output logic              rvalid,
    output logic              rdirty,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [LINE_W-1:0] wline,
    input  logic [TAG_W-1:0]  wtag,
    input  logic              wvalid,
    input  logic              wdirty
);

    logic [LINE_W-1:0] data_mem [SETS];
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [SETS-1:0]   valid;
    logic [SETS-1:0]   dirty;

    assign rline  = data_mem[ridx];
    assign rtag   = tag_mem[ridx];
    assign rvalid = valid[ridx];
    assign rdirty = dirty[ridx];

    // Payload arrays carry no reset; only the state bits are cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            data_mem[widx] <= wline;
            tag_mem[widx]  <= wtag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (we) begin
            valid[widx] <= wvalid;
            dirty[widx] <= wdirty;
        end
    end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate D-cache; done 2 cycles after enable on a hit, 1 cycle after fill ddone on a miss.
// Core holds enable until done; memory side holds drequest until dreqack, one transaction in flight.
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int SETS   = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                wen,
    input  logic [63:0]         addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                done,
    input  logic                flush,
    output logic                flush_done,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt,
    dcache_wb_if.master         mem
);

    localparam int WBYTES = DATA_W / 8;
    localparam int BSEL_W = $clog2(WBYTES);
    localparam int WSEL_W = OFF_W - BSEL_W;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 64 - OFF_W - IDX_W;
    localparam int CAP_W  = 64 - BSEL_W;
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

    state_t state, state_nxt;

    // Captured address drops the in-word byte bits: {tag, idx, word select}.
    logic [CAP_W-1:0]  cap_addr;
    logic              cap_wen;
    logic [DATA_W-1:0] cap_wdata;
    logic [WBYTES-1:0] cap_wstrb;
    logic [IDX_W-1:0]  flush_ptr;
    logic              acked;
    logic [DATA_W-1:0] resp_dat;

    logic [WSEL_W-1:0] word_sel;
    logic [IDX_W-1:0]  cap_idx;
    logic [TAG_W-1:0]  cap_tag;

    logic [IDX_W-1:0]  arr_idx;
    logic [LINE_W-1:0] rline;
    logic [TAG_W-1:0]  rtag;
    logic              rvalid;
    logic              rdirty;
    logic              we;
    logic [LINE_W-1:0] wline;
    logic [TAG_W-1:0]  wtag;
    logic              wvalid;
    logic              wdirty;

    logic              hit;
    logic              victim_dirty;
    logic              last_set;
    logic              mem_state;
    logic              flush_end;
    logic              mem_req;
    logic              mem_wr;
    logic [63:0]       mem_addr;
    logic [LINE_W-1:0] mem_line;
    logic [LINE_W-1:0] hit_merge;
    logic [LINE_W-1:0] fill_merge;

    assign word_sel = cap_addr[WSEL_W-1:0];
    assign cap_idx  = cap_addr[WSEL_W +: IDX_W];
    assign cap_tag  = cap_addr[CAP_W-1 -: TAG_W];

    assign arr_idx      = (state == FLUSH_SCAN || state == FLUSH_WB) ? flush_ptr : cap_idx;
    assign hit          = rvalid && (rtag == cap_tag);
    assign victim_dirty = rvalid && rdirty;
    assign last_set     = (flush_ptr == LAST_SET);
    assign mem_state    = (state == WB) || (state == FILL) || (state == FLUSH_WB);

    assign hit_merge  = merge_word(rline, 64'(cap_wdata), 8'(cap_wstrb), int'(word_sel), WBYTES);
    assign fill_merge = merge_word(mem.drdata, 64'(cap_wdata), 8'(cap_wstrb), int'(word_sel), WBYTES);

    dcache_array #(
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .ridx    (arr_idx),
        .rline   (rline),
        .rtag    (rtag),
        .rvalid  (rvalid),
        .rdirty  (rdirty),
        .we      (we),
        .widx    (arr_idx),
        .wline   (wline),
        .wtag    (wtag),
        .wvalid  (wvalid),
        .wdirty  (wdirty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        wline     = rline;
        wtag      = rtag;
        wvalid    = 1'b1;
        wdirty    = rdirty;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_line  = '0;
        flush_end = 1'b0;
        case (state)
            IDLE: begin
                if (enable)     state_nxt = LOOKUP;
                else if (flush) state_nxt = FLUSH_SCAN;
            end
            LOOKUP: begin
                if (hit) begin
                    state_nxt = RESP;
                    if (cap_wen) begin
                        we     = 1'b1;
                        wline  = hit_merge;
                        wdirty = 1'b1;
                    end
                end else if (victim_dirty) begin
                    state_nxt = WB;
                end else begin
                    state_nxt = FILL;
                end
            end
            WB: begin
                mem_req  = !acked;
                mem_wr   = 1'b1;
                mem_addr = {rtag, cap_idx, 6'b0};
                mem_line = rline;
                if (mem.ddone) state_nxt = FILL;
            end
            FILL: begin
                mem_req  = !acked;
                mem_addr = {cap_tag, cap_idx, 6'b0};
                if (mem.ddone) begin
                    we        = 1'b1;
                    wtag      = cap_tag;
                    wline     = cap_wen ? fill_merge : mem.drdata;
                    wdirty    = cap_wen;
                    state_nxt = RESP;
                end
            end
            RESP: state_nxt = IDLE;
            FLUSH_SCAN: begin
                if (victim_dirty) begin
                    state_nxt = FLUSH_WB;
                end else if (last_set) begin
                    flush_end = 1'b1;
                    state_nxt = IDLE;
                end
            end
            FLUSH_WB: begin
                mem_req  = !acked;
                mem_wr   = 1'b1;
                mem_addr = {rtag, flush_ptr, 6'b0};
                mem_line = rline;
                if (mem.ddone) begin
                    we     = 1'b1;
                    wdirty = 1'b0;
                    if (last_set) begin
                        flush_end = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = FLUSH_SCAN;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_addr   <= '0;
            cap_wen    <= 1'b0;
            cap_wdata  <= '0;
            cap_wstrb  <= '0;
            flush_ptr  <= '0;
            acked      <= 1'b0;
            resp_dat   <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= flush_end;
            // acked suppresses drequest after dreqack until ddone closes the transaction.
            if (mem_state) begin
                if (mem.ddone)        acked <= 1'b0;
                else if (mem.dreqack) acked <= 1'b1;
            end else begin
                acked <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        cap_addr  <= addr[63:BSEL_W];
                        cap_wen   <= wen;
                        cap_wdata <= wdata;
                        cap_wstrb <= wstrb;
                    end else if (flush) begin
                        flush_ptr <= '0;
                    end
                end
                LOOKUP: begin
                    if (hit) hit_cnt  <= hit_cnt + 32'd1;
                    else     miss_cnt <= miss_cnt + 32'd1;
                    resp_dat <= (hit && !cap_wen) ? rline[word_sel * DATA_W +: DATA_W] : '0;
                end
                FILL: begin
                    if (mem.ddone)
                        resp_dat <= cap_wen ? '0 : mem.drdata[word_sel * DATA_W +: DATA_W];
                end
                FLUSH_SCAN: begin
                    if (!victim_dirty && !last_set) flush_ptr <= flush_ptr + 1'b1;
                end
                FLUSH_WB: begin
                    if (mem.ddone) flush_ptr <= flush_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done  = (state == RESP);
    assign rdata = (state == RESP) ? resp_dat : '0;

    assign mem.drequest  = mem_req;
    assign mem.dwrenable = mem_wr;
    assign mem.daddr     = mem_addr;
    assign mem.dwdata    = mem_line;

    assert property (@(posedge clk) disable iff (!reset_n)
        (state == IDLE && enable) |-> (addr[BSEL_W-1:0] == '0))
        else $fatal(1, "dcache_wb: misaligned core address");

endmodule

// File: tb/tb_dcache_wb.sv
// Scoreboard bench for dcache_wb: directed loads/stores/flushes against a simple line-memory model.
module tb_dcache_wb;
    import dcache_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata;
    logic        done;
    logic        flush;
    logic        flush_done;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    dcache_wb_if mi();

    dcache_wb #(.SETS(64), .DATA_W(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .wen        (wen),
        .addr       (addr),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .rdata      (rdata),
        .done       (done),
        .flush      (flush),
        .flush_done (flush_done),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt),
        .mem        (mi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              wr;
        logic [63:0]       a;
        logic [LINE_W-1:0] line;
    } mtx_t;

    logic [63:0] exp_resp [$];
    mtx_t        exp_mem  [$];
    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;
    int mem_lat = 2;
    bit mem_stall = 1'b0;

    // Memory line content: word i = {line address[31:0], i}.
    function automatic logic [LINE_W-1:0] fill_line(input logic [63:0] a);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < 8; i++) l[i * 64 +: 64] = {a[31:0], 32'(i)};
        return l;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_mem(input logic wr, input logic [63:0] a, input logic [LINE_W-1:0] line);
        mtx_t m;
        m.wr = wr;
        m.a = a;
        m.line = line;
        exp_mem.push_back(m);
    endtask

    // Memory model: acks a request in the cycle it first sees it, ddone mem_lat cycles later.
    initial begin
        int          cnt;
        bit          busy;
        logic [63:0] cur;
        busy = 1'b0;
        cnt = 0;
        cur = '0;
        mi.dreqack = 1'b0;
        mi.ddone = 1'b0;
        mi.drdata = '0;
        forever begin
            @(negedge clk);
            mi.dreqack = 1'b0;
            mi.ddone = 1'b0;
            if (!reset_n) begin
                busy = 1'b0;
            end else if (!busy) begin
                if (mi.drequest) begin
                    mi.dreqack = 1'b1;
                    cur = mi.daddr;
                    cnt = mem_lat;
                    if (cnt == 0) begin
                        mi.ddone = 1'b1;
                        mi.drdata = fill_line(cur);
                    end else begin
                        busy = 1'b1;
                    end
                end
            end else if (!mem_stall) begin
                cnt--;
                if (cnt <= 0) begin
                    mi.ddone = 1'b1;
                    mi.drdata = fill_line(cur);
                    busy = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expected core responses on done and expected memory transactions on the ack cycle.
    initial begin
        mtx_t m;
        forever begin
            @(negedge clk);
            #1;
            if (done) begin
                if (exp_resp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: rdata %h with no response expected", rdata);
                end else begin
                    chk("rdata", rdata, exp_resp.pop_front());
                end
            end
            if (mi.drequest && mi.dreqack) begin
                if (exp_mem.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_mem: wr %0b daddr %h with no transaction expected",
                             mi.dwrenable, mi.daddr);
                end else begin
                    m = exp_mem.pop_front();
                    chk("mem_wr", 64'(mi.dwrenable), 64'(m.wr));
                    chk("mem_addr", mi.daddr, m.a);
                    if (m.wr) chk_line("mem_wdata", mi.dwdata, m.line);
                end
            end
            if (flush_done) fd_cnt++;
        end
    end

    task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] s, input logic [63:0] exp_rd, input int exp_lat);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        exp_resp.push_back(exp_rd);
        @(negedge clk);
        enable = 1'b1;
        wen = w;
        addr = a;
        wdata = d;
        wstrb = s;
        while (!got && n < 300) begin
            @(negedge clk);
            #1;
            n++;
            if (done) got = 1'b1;
        end
        enable = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL req_timeout: addr %h got no done within %0d cycles", a, n);
            void'(exp_resp.pop_back());
        end else if (exp_lat >= 0) begin
            chk("hit_latency", 64'(n), 64'(exp_lat));
        end
    endtask

    task automatic do_flush();
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        while (!got && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
            if (flush_done) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL flush_timeout: no flush_done within %0d cycles", n);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [LINE_W-1:0] l;
        reset_n = 1'b0;
        enable = 1'b0;
        wen = 1'b0;
        addr = '0;
        wdata = '0;
        wstrb = '0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        chk("rst_drequest", 64'(mi.drequest), 64'd0);
        chk("rst_daddr", mi.daddr, 64'd0);
        chk("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // cold miss, then hit on the neighbouring word
        push_mem(1'b0, 64'h1000, '0);
        do_req(1'b0, 64'h1000, '0, 8'h00, 64'h0000_1000_0000_0000, -1);
        chk("miss_cnt_1", 64'(miss_cnt), 64'd1);
        chk("hit_cnt_0", 64'(hit_cnt), 64'd0);
        do_req(1'b0, 64'h1008, '0, 8'h00, 64'h0000_1000_0000_0001, 2);
        chk("hit_cnt_1", 64'(hit_cnt), 64'd1);

        // partial store hit, then read back the merged word
        do_req(1'b1, 64'h1008, 64'hAABB_CCDD_1122_3344, 8'h0F, 64'd0, 2);
        do_req(1'b0, 64'h1008, '0, 8'h00, 64'h0000_1000_1122_3344, 2);
        chk("hit_cnt_3", 64'(hit_cnt), 64'd3);

        // conflict miss on a dirty victim: write-back of 0x1000 then fill of 0x2000
        l = fill_line(64'h1000);
        l[1 * 64 +: 64] = 64'h0000_1000_1122_3344;
        push_mem(1'b1, 64'h1000, l);
        push_mem(1'b0, 64'h2000, '0);
        do_req(1'b0, 64'h2008, '0, 8'h00, 64'h0000_2000_0000_0001, -1);
        chk("miss_cnt_2", 64'(miss_cnt), 64'd2);

        // store miss with ddone in the ack cycle, then a store hit in set 0
        mem_lat = 0;
        push_mem(1'b0, 64'h1040, '0);
        do_req(1'b1, 64'h1040, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, -1);
        mem_lat = 2;
        do_req(1'b1, 64'h2010, 64'hDEAD_BEEF_0000_0000, 8'hF0, 64'd0, 2);
        chk("miss_cnt_3", 64'(miss_cnt), 64'd3);
        chk("hit_cnt_4", 64'(hit_cnt), 64'd4);

        // flush: set 0 then set 1 written back, counters untouched
        l = fill_line(64'h2000);
        l[2 * 64 +: 64] = 64'hDEAD_BEEF_0000_0002;
        push_mem(1'b1, 64'h2000, l);
        l = fill_line(64'h1040);
        l[0 +: 64] = 64'h0123_4567_89AB_CDEF;
        push_mem(1'b1, 64'h1040, l);
        do_flush();
        chk("flush_done_cnt_1", 64'(fd_cnt), 64'd1);
        chk("flush_hit_cnt", 64'(hit_cnt), 64'd4);
        chk("flush_miss_cnt", 64'(miss_cnt), 64'd3);
        chk("flush_mem_left", 64'(exp_mem.size()), 64'd0);

        // second flush finds nothing dirty; line stays valid
        do_flush();
        chk("flush_done_cnt_2", 64'(fd_cnt), 64'd2);
        do_req(1'b0, 64'h1040, '0, 8'h00, 64'h0123_4567_89AB_CDEF, 2);
        chk("hit_cnt_5", 64'(hit_cnt), 64'd5);

        // reset while the fill waits on ddone
        mem_stall = 1'b1;
        push_mem(1'b0, 64'h3000, '0);
        @(negedge clk);
        enable = 1'b1;
        wen = 1'b0;
        addr = 64'h3000;
        repeat (6) @(negedge clk);
        chk("stall_daddr", mi.daddr, 64'h3000);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_daddr", mi.daddr, 64'd0);
        chk("abort_drequest", 64'(mi.drequest), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hit_cnt", 64'(hit_cnt), 64'd0);
        chk("abort_miss_cnt", 64'(miss_cnt), 64'd0);
        enable = 1'b0;
        mem_stall = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        push_mem(1'b0, 64'h3000, '0);
        do_req(1'b0, 64'h3000, '0, 8'h00, 64'h0000_3000_0000_0000, -1);
        push_mem(1'b0, 64'h1040, '0);
        do_req(1'b0, 64'h1040, '0, 8'h00, 64'h0000_1040_0000_0000, -1);
        chk("post_rst_miss_cnt", 64'(miss_cnt), 64'd2);
        chk("post_rst_hit_cnt", 64'(hit_cnt), 64'd0);

        repeat (4) @(negedge clk);
        chk("resp_left", 64'(exp_resp.size()), 64'd0);
        chk("mem_left", 64'(exp_mem.size()), 64'd0);
        chk("flush_done_total", 64'(fd_cnt), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache between the core load/store port and the 512-bit line memory interface.
- Replaces the pass-through line cache. Adds tag/valid/dirty storage, byte-strobed word writes, hit/miss counters and a full-cache flush.
- Memory-side handshake (drequest/dreqack/ddone) is unchanged, so the block drops into the existing memory arbiter.

Parameters:
- SETS, 64, number of lines; power of two, at least 2.
- DATA_W, 64, core word width in bits; one of 32 or 64.
- LINE_W, 512, line width in bits; must equal the memory data bus width. OFF_W = 6.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  core request; held until done
- wen  in  1  1 = store, 0 = load
- addr  in  64  byte address; aligned to DATA_W/8
- wdata  in  DATA_W  store data
- wstrb  in  DATA_W/8  store byte enables
- rdata  out  DATA_W  load data; valid only while done is high
- done  out  1  one-cycle completion pulse
- flush  in  1  write back all dirty lines
- flush_done  out  1  one-cycle pulse when the flush completes
- hit_cnt  out  32  lookup hit count, wraps
- miss_cnt  out  32  lookup miss count, wraps
- drequest  out  1  memory request
- dreqack  in  1  memory accepted the request
- dwrenable  out  1  1 = line write, 0 = line read
- daddr  out  64  line address; low 6 bits always 0
- drdata  in  LINE_W  fill data
- dwdata  out  LINE_W  write-back data
- ddone  in  1  memory transaction complete (pulse)

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0, every valid and dirty bit cleared, counters 0, state IDLE. Tag and data arrays are not reset.
- Reset mid-transaction aborts it immediately. The memory side must also be reset.
- Address split: offset = addr[5:0], idx = addr[OFF_W +: log2(SETS)], tag = remaining upper bits. Word select = addr[5:log2(DATA_W/8)].
- Misalignment: enable with a misaligned addr in IDLE raises $fatal.
- IDLE:
  - enable && !done: capture addr/wen/wdata/wstrb, go to LOOKUP.
  - else flush: go to FLUSH_SCAN with set pointer 0.
  - enable has priority over flush.
  - Inputs are not sampled in the cycle done is high.
- LOOKUP:
  - hit = valid[idx] && tag match. Increment hit_cnt or miss_cnt.
  - Hit: load returns the selected word; store merges wdata bytes per wstrb and sets dirty. Go to RESP.
  - Miss with clean or invalid victim: go to FILL.
  - Miss with dirty victim: go to WB, daddr = {victim tag, idx, 6'b0}, dwdata = victim line.
- Memory handshake (WB, FILL, FLUSH_WB):
  - Assert drequest with daddr/dwrenable/dwdata stable.
  - Drop drequest the cycle after dreqack is sampled high.
  - The transaction ends on ddone; ddone may arrive in the same cycle as dreqack.
  - At most one outstanding transaction.
- WB: on ddone go to FILL.
- FILL: dwrenable = 0, daddr = {tag, idx, 6'b0}.
  - On ddone install drdata, set valid, write tag.
  - For a store, merge wdata into the installed line in the same cycle and set dirty; else clear dirty.
  - Go to RESP.
- RESP: done = 1 for exactly one cycle. rdata = loaded word for loads, 0 for stores. Then IDLE; rdata returns to 0.
- Latency (enable sampled high in cycle 0):
  - Hit: done in cycle 2.
  - Miss: done 1 cycle after the fill's ddone.
- FLUSH_SCAN: one set per cycle.
  - Dirty: go to FLUSH_WB (dwrenable = 1), then on ddone clear dirty (valid kept) and resume at the same set pointer +1.
  - After set SETS-1: flush_done = 1 for one cycle, return to IDLE.
  - enable is ignored until IDLE.
  - flush held high after flush_done starts a new flush.
- Counters wrap modulo 2^32 and are not touched by flush.

Decomposition:
- Package dcache_pkg: state enum {IDLE, LOOKUP, WB, FILL, RESP, FLUSH_SCAN, FLUSH_WB}, LINE_W, OFF_W, and a function merging a strobed word into a line at a word offset.
- Sub-module dcache_array: tag/valid/dirty/data storage.
  - Combinational read by idx.
  - One synchronous write port (line, tag, valid, dirty).
  - Asynchronous clear of valid/dirty.

Test Plan:
- After reset, load 0x1000 -> miss, one FILL read at daddr 0x1000; done pulses with the drdata word 0; hit_cnt=0, miss_cnt=1.
- Repeat load 0x1008 -> no memory request; done exactly 2 cycles after enable; rdata = word 1 of the filled line; hit_cnt=1.
- Store 0x1008, wdata 0xAABBCCDD_11223344, wstrb 0x0F -> only bytes 0-3 change. Line goes dirty; a following load 0x1008 returns the merged word.
- With SETS=64, load 0x2008 (same idx as 0x1000, dirty) -> write-back at daddr 0x1000 with the merged line, then a fill read of 0x2000, then done.
- Flush with two dirty lines -> exactly two line writes in ascending set order; flush_done pulses once; a second flush issues no memory requests.
- Assert reset_n low while FILL is waiting on ddone -> outputs 0 immediately; the next load of the same address misses.
